// File: rtl/pipeline_hazard_unit_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding controller.
package pipeline_hazard_pkg;

    // Slot records carry dest zero-extended to this width; REG_ADDR_W must not exceed it.
    localparam int unsigned REG_ADDR_W_MAX = 8;

    // Forwarding select value meaning "take the operand from the register file".
    localparam int unsigned FWD_REGFILE = 0;

    typedef struct packed {
        logic                      valid;
        logic [REG_ADDR_W_MAX-1:0] dest;
        logic                      reg_write;
        logic                      is_load;
    } slot_t;

    // Forwarding select width: clog2 of the slot count, never below one bit.
    function automatic int unsigned sel_w(input int unsigned n_slots);
        return (n_slots <= 2) ? 1 : $clog2(n_slots);
    endfunction

endpackage

// File: rtl/pipeline_hazard_unit_if.sv
// ID-stage request and hazard-control response bundle between the core and the hazard unit.
interface pipeline_hazard_unit_if
    import pipeline_hazard_pkg::*;
#(
    parameter int unsigned N_SLOTS    = 3,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
);
    localparam int unsigned SEL_W = sel_w(N_SLOTS);

    logic                  id_valid_i;
    logic [REG_ADDR_W-1:0] id_rs_i;
    logic [REG_ADDR_W-1:0] id_rt_i;
    logic                  id_use_rs_i;
    logic                  id_use_rt_i;
    logic [REG_ADDR_W-1:0] id_dest_i;
    logic                  id_reg_write_i;
    logic                  id_is_load_i;
    logic                  redirect_i;
    logic                  freeze_i;

    logic                  stall_o;
    logic                  bubble_o;
    logic                  flush_o;
    logic [SEL_W-1:0]      fwd_a_sel_o;
    logic [SEL_W-1:0]      fwd_b_sel_o;
    logic [N_SLOTS-1:0]    slot_valid_o;
    logic [CNT_W-1:0]      stall_cnt_o;
    logic [CNT_W-1:0]      flush_cnt_o;

    // Core side: presents the ID instruction, consumes hazard controls.
    modport master (
        output id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
               id_dest_i, id_reg_write_i, id_is_load_i, redirect_i, freeze_i,
        input  stall_o, bubble_o, flush_o, fwd_a_sel_o, fwd_b_sel_o,
               slot_valid_o, stall_cnt_o, flush_cnt_o
    );

    // Hazard unit side.
    modport slave (
        input  id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
               id_dest_i, id_reg_write_i, id_is_load_i, redirect_i, freeze_i,
        output stall_o, bubble_o, flush_o, fwd_a_sel_o, fwd_b_sel_o,
               slot_valid_o, stall_cnt_o, flush_cnt_o
    );

endinterface

// File: rtl/pipeline_hazard_unit_slot_chain.sv
// Scoreboard shift register: one record per post-ID stage, slot 0 = EX.
module hazard_slot_chain
    import pipeline_hazard_pkg::*;
#(
    parameter int unsigned N_SLOTS = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_freeze,
    input  slot_t                   i_insert,
    input  logic [N_SLOTS-1:1]      i_kill,
    output slot_t [N_SLOTS-1:0]     o_slots
);

    slot_t [N_SLOTS-1:0] r_slots;

    // Advance every unfrozen edge; killed slots leave with their valid bit cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_slots <= '0;
        end else if (!i_freeze) begin
            r_slots[0] <= i_insert;
            for (int unsigned k = 1; k < N_SLOTS; k++) begin
                r_slots[k]       <= r_slots[k-1];
                r_slots[k].valid <= r_slots[k-1].valid && !i_kill[k];
            end
        end
    end

    assign o_slots = r_slots;

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Load-use stall, redirect flush, freeze and registered EX forwarding selects.
module pipeline_hazard_unit
    import pipeline_hazard_pkg::*;
#(
    parameter int unsigned N_SLOTS        = 3,
    parameter int unsigned REG_ADDR_W     = 5,
    parameter int unsigned REDIRECT_STAGE = 1,
    parameter int unsigned CNT_W          = 16
) (
    input logic                   clk,
    input logic                   reset,
    pipeline_hazard_unit_if.slave hz_if
);

    localparam int unsigned      SEL_W       = sel_w(N_SLOTS);
    localparam logic [SEL_W-1:0] SEL_REGFILE = SEL_W'(FWD_REGFILE);

    slot_t [N_SLOTS-1:0]       w_slots;
    slot_t                     w_insert;
    logic [N_SLOTS-1:1]        w_kill;
    logic [REG_ADDR_W_MAX-1:0] w_rs;
    logic [REG_ADDR_W_MAX-1:0] w_rt;
    logic [N_SLOTS-1:0]        w_match_a;
    logic [N_SLOTS-1:0]        w_match_b;
    logic [N_SLOTS-1:0]        w_is_load;
    logic                      w_freeze;
    logic                      w_redirect;
    logic                      w_load_use;
    logic                      w_advance_normal;
    logic [SEL_W-1:0]          w_sel_a;
    logic [SEL_W-1:0]          w_sel_b;
    logic [SEL_W-1:0]          r_fwd_a_sel;
    logic [SEL_W-1:0]          r_fwd_b_sel;
    logic [CNT_W-1:0]          r_stall_cnt;
    logic [CNT_W-1:0]          r_flush_cnt;
    logic                      w_unused;

    // Register 0 is hard-wired zero, so it never matches a producer.
    function automatic logic slot_match(input slot_t s, input logic [REG_ADDR_W_MAX-1:0] src);
        return s.valid && s.reg_write && (s.dest == src) && (src != '0);
    endfunction

    hazard_slot_chain #(
        .N_SLOTS (N_SLOTS)
    ) u_chain (
        .clk      (clk),
        .reset    (reset),
        .i_freeze (w_freeze),
        .i_insert (w_insert),
        .i_kill   (w_kill),
        .o_slots  (w_slots)
    );

    assign w_rs = REG_ADDR_W_MAX'(hz_if.id_rs_i);
    assign w_rt = REG_ADDR_W_MAX'(hz_if.id_rt_i);

    // Per-slot source matches, qualified by the operand use bits.
    always_comb begin
        w_match_a = '0;
        w_match_b = '0;
        w_is_load = '0;
        for (int unsigned k = 0; k < N_SLOTS; k++) begin
            w_match_a[k] = hz_if.id_use_rs_i && slot_match(w_slots[k], w_rs);
            w_match_b[k] = hz_if.id_use_rt_i && slot_match(w_slots[k], w_rt);
            w_is_load[k] = w_slots[k].is_load;
        end
    end

    // A redirect only counts when the slot that resolves it holds a real instruction.
    assign w_freeze         = hz_if.freeze_i;
    assign w_redirect       = hz_if.redirect_i && w_slots[REDIRECT_STAGE].valid;
    assign w_load_use       = hz_if.id_valid_i && w_is_load[0] && (w_match_a[0] || w_match_b[0]);
    assign w_advance_normal = !w_freeze && !w_redirect && !w_load_use;

    assign hz_if.stall_o  = w_freeze || (!w_redirect && w_load_use);
    assign hz_if.bubble_o = !w_freeze && !w_redirect && w_load_use;
    assign hz_if.flush_o  = !w_freeze && w_redirect;

    // Slot 0 takes the ID record only on a normal advance; a redirect also kills 1..REDIRECT_STAGE.
    always_comb begin
        w_insert = '0;
        w_kill   = '0;
        if (w_advance_normal) begin
            w_insert.valid     = hz_if.id_valid_i;
            w_insert.dest      = REG_ADDR_W_MAX'(hz_if.id_dest_i);
            w_insert.reg_write = hz_if.id_reg_write_i;
            w_insert.is_load   = hz_if.id_is_load_i;
        end
        for (int unsigned k = 1; k < N_SLOTS; k++) begin
            w_kill[k] = w_redirect && (k <= REDIRECT_STAGE);
        end
    end

    // Youngest match wins: scan oldest-to-youngest so the lowest index is written last.
    // The WB slot is skipped since the register file writes through.
    always_comb begin
        w_sel_a = SEL_REGFILE;
        w_sel_b = SEL_REGFILE;
        for (int j = int'(N_SLOTS) - 2; j >= 0; j--) begin
            if (w_match_a[j]) w_sel_a = SEL_W'(j + 1);
            if (w_match_b[j]) w_sel_b = SEL_W'(j + 1);
        end
    end

    // Forwarding selects follow the ID instruction into EX; stalls and flushes clear them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fwd_a_sel <= SEL_REGFILE;
            r_fwd_b_sel <= SEL_REGFILE;
        end else if (w_advance_normal) begin
            r_fwd_a_sel <= w_sel_a;
            r_fwd_b_sel <= w_sel_b;
        end else if (!w_freeze) begin
            r_fwd_a_sel <= SEL_REGFILE;
            r_fwd_b_sel <= SEL_REGFILE;
        end
    end

    // Saturating event counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (!w_freeze) begin
            if (w_redirect && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
            if (!w_redirect && w_load_use && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    // Expose the scoreboard valid bits.
    always_comb begin
        hz_if.slot_valid_o = '0;
        for (int unsigned k = 0; k < N_SLOTS; k++) begin
            hz_if.slot_valid_o[k] = w_slots[k].valid;
        end
    end

    assign hz_if.fwd_a_sel_o = r_fwd_a_sel;
    assign hz_if.fwd_b_sel_o = r_fwd_b_sel;
    assign hz_if.stall_cnt_o = r_stall_cnt;
    assign hz_if.flush_cnt_o = r_flush_cnt;

    // WB-slot matches and older load flags have no consumer.
    assign w_unused = ^{w_match_a[N_SLOTS-1], w_match_b[N_SLOTS-1], w_is_load[N_SLOTS-1:1]};

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Self-checking bench: directed scenarios plus randomized traffic against a scoreboard model.
module tb_pipeline_hazard_unit;

    localparam int N  = 3;
    localparam int RS = 1;
    localparam int RW = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    pipeline_hazard_unit_if #(.N_SLOTS(N), .REG_ADDR_W(RW), .CNT_W(16)) hz ();
    pipeline_hazard_unit_if #(.N_SLOTS(N), .REG_ADDR_W(RW), .CNT_W(2))  hz_sat ();

    pipeline_hazard_unit #(
        .N_SLOTS(N), .REG_ADDR_W(RW), .REDIRECT_STAGE(RS), .CNT_W(16)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .hz_if (hz)
    );

    pipeline_hazard_unit #(
        .N_SLOTS(N), .REG_ADDR_W(RW), .REDIRECT_STAGE(RS), .CNT_W(2)
    ) dut_sat (
        .clk   (clk),
        .reset (rst_n),
        .hz_if (hz_sat)
    );

    assign hz_sat.id_valid_i     = hz.id_valid_i;
    assign hz_sat.id_rs_i        = hz.id_rs_i;
    assign hz_sat.id_rt_i        = hz.id_rt_i;
    assign hz_sat.id_use_rs_i    = hz.id_use_rs_i;
    assign hz_sat.id_use_rt_i    = hz.id_use_rt_i;
    assign hz_sat.id_dest_i      = hz.id_dest_i;
    assign hz_sat.id_reg_write_i = hz.id_reg_write_i;
    assign hz_sat.id_is_load_i   = hz.id_is_load_i;
    assign hz_sat.redirect_i     = hz.redirect_i;
    assign hz_sat.freeze_i       = hz.freeze_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: in-flight instructions, index 0 = EX.
    bit m_valid [N];
    int m_dest  [N];
    bit m_wr    [N];
    bit m_ld    [N];
    int m_sel_a, m_sel_b;
    int m_stall, m_flush;

    function automatic bit m_match(input int k, input int src);
        return m_valid[k] && m_wr[k] && (m_dest[k] == src) && (src != 0);
    endfunction

    function automatic bit m_hazard();
        return hz.id_valid_i && m_valid[0] && m_ld[0] &&
               ((hz.id_use_rs_i && m_match(0, int'(hz.id_rs_i))) ||
                (hz.id_use_rt_i && m_match(0, int'(hz.id_rt_i))));
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    always @(posedge clk or negedge rst_n) begin : p_model
        bit haz;
        bit redir;
        int na;
        int nb;
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                m_valid[k] = 0; m_dest[k] = 0; m_wr[k] = 0; m_ld[k] = 0;
            end
            m_sel_a = 0; m_sel_b = 0; m_stall = 0; m_flush = 0;
        end else if (!hz.freeze_i) begin
            haz   = m_hazard();
            redir = hz.redirect_i;
            na = 0;
            nb = 0;
            if (!redir && !haz) begin
                for (int j = N - 2; j >= 0; j--) begin
                    if (hz.id_use_rs_i && m_match(j, int'(hz.id_rs_i))) na = j + 1;
                    if (hz.id_use_rt_i && m_match(j, int'(hz.id_rt_i))) nb = j + 1;
                end
            end
            for (int k = N - 1; k >= 1; k--) begin
                m_valid[k] = m_valid[k-1]; m_dest[k] = m_dest[k-1];
                m_wr[k] = m_wr[k-1]; m_ld[k] = m_ld[k-1];
            end
            if (redir) begin
                m_valid[0] = 0;
                for (int k = 1; k <= RS; k++) m_valid[k] = 0;
                m_flush++;
            end else if (haz) begin
                m_valid[0] = 0;
                m_stall++;
            end else begin
                m_valid[0] = hz.id_valid_i;
                m_dest[0]  = int'(hz.id_dest_i);
                m_wr[0]    = hz.id_reg_write_i;
                m_ld[0]    = hz.id_is_load_i;
            end
            m_sel_a = na;
            m_sel_b = nb;
        end
    end

    // Every cycle: DUT outputs against the model, sampled mid-cycle.
    always @(negedge clk) begin : p_compare
        bit haz;
        bit redir;
        bit frz;
        logic [N-1:0] vexp;
        haz   = m_hazard();
        redir = hz.redirect_i;
        frz   = hz.freeze_i;
        for (int k = 0; k < N; k++) vexp[k] = m_valid[k];
        check("stall_o",      32'(hz.stall_o),      32'(frz | (!redir & haz)));
        check("bubble_o",     32'(hz.bubble_o),     32'(!frz & !redir & haz));
        check("flush_o",      32'(hz.flush_o),      32'(!frz & redir));
        check("slot_valid_o", 32'(hz.slot_valid_o), 32'(vexp));
        check("fwd_a_sel_o",  32'(hz.fwd_a_sel_o),  m_sel_a);
        check("fwd_b_sel_o",  32'(hz.fwd_b_sel_o),  m_sel_b);
        check("stall_cnt_o",  32'(hz.stall_cnt_o),  sat(m_stall, 65535));
        check("flush_cnt_o",  32'(hz.flush_cnt_o),  sat(m_flush, 65535));
        check("sat_stall_cnt", 32'(hz_sat.stall_cnt_o), sat(m_stall, 3));
        check("sat_flush_cnt", 32'(hz_sat.flush_cnt_o), sat(m_flush, 3));
    end

    task automatic set_in(input int v, input int rs, input int rt, input int urs, input int urt,
                          input int dest, input int wr, input int ld);
        hz.id_valid_i     = (v != 0);
        hz.id_rs_i        = RW'(rs);
        hz.id_rt_i        = RW'(rt);
        hz.id_use_rs_i    = (urs != 0);
        hz.id_use_rt_i    = (urt != 0);
        hz.id_dest_i      = RW'(dest);
        hz.id_reg_write_i = (wr != 0);
        hz.id_is_load_i   = (ld != 0);
        hz.redirect_i     = 1'b0;
        hz.freeze_i       = 1'b0;
    endtask

    task automatic nop();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle with no literal checks.
    task automatic cyc();
        @(negedge clk);
        tick();
    endtask

    initial begin
        nop();
        #1 rst_n = 1'b0;
        #1;
        check("rst_slot_valid", 32'(hz.slot_valid_o), 0);
        check("rst_fwd_a", 32'(hz.fwd_a_sel_o), 0);
        check("rst_stall_cnt", 32'(hz.stall_cnt_o), 0);
        check("rst_flush_o", 32'(hz.flush_o), 0);
        tick();
        rst_n = 1'b1;

        // Back-to-back dependency, then one independent instruction between.
        set_in(1, 1, 2, 1, 1, 3, 1, 0); cyc();
        set_in(1, 3, 5, 1, 1, 4, 1, 0);
        @(negedge clk); check("t2_no_stall", 32'(hz.stall_o), 0); tick();
        nop();
        @(negedge clk);
        check("t2_fwd_a_1", 32'(hz.fwd_a_sel_o), 1);
        check("t2_fwd_b_0", 32'(hz.fwd_b_sel_o), 0);
        tick();
        set_in(1, 1, 2, 1, 1, 7, 1, 0); cyc();
        set_in(1, 1, 1, 1, 1, 8, 1, 0); cyc();
        set_in(1, 7, 2, 1, 1, 9, 1, 0); cyc();
        nop();
        @(negedge clk); check("t2_fwd_a_2", 32'(hz.fwd_a_sel_o), 2); tick();

        // Load-use: one stall cycle, then forward from MEM.
        set_in(1, 1, 0, 1, 0, 2, 1, 1); cyc();
        set_in(1, 2, 2, 1, 1, 6, 1, 0);
        @(negedge clk);
        check("t3_stall", 32'(hz.stall_o), 1);
        check("t3_bubble", 32'(hz.bubble_o), 1);
        tick();
        @(negedge clk); check("t3_stall_released", 32'(hz.stall_o), 0); tick();
        nop();
        @(negedge clk);
        check("t3_fwd_a", 32'(hz.fwd_a_sel_o), 2);
        check("t3_fwd_b", 32'(hz.fwd_b_sel_o), 2);
        check("t3_stall_cnt", 32'(hz.stall_cnt_o), 1);
        tick();

        // $0 never forwards; an unused operand never forwards.
        set_in(1, 1, 1, 1, 1, 0, 1, 0); cyc();
        set_in(1, 0, 0, 1, 1, 10, 1, 0);
        @(negedge clk); check("t4_no_stall_r0", 32'(hz.stall_o), 0); tick();
        nop();
        @(negedge clk);
        check("t4_r0_fwd_a", 32'(hz.fwd_a_sel_o), 0);
        check("t4_r0_fwd_b", 32'(hz.fwd_b_sel_o), 0);
        tick();
        set_in(1, 1, 1, 1, 1, 3, 1, 0); cyc();
        set_in(1, 3, 1, 0, 1, 11, 1, 0); cyc();
        nop();
        @(negedge clk); check("t4_unused_rs", 32'(hz.fwd_a_sel_o), 0); tick();

        // Taken branch resolving in MEM flushes the EX instruction.
        set_in(1, 1, 1, 1, 1, 0, 0, 0); cyc();
        set_in(1, 1, 1, 1, 1, 12, 1, 0); cyc();
        set_in(1, 1, 1, 1, 1, 13, 1, 0);
        hz.redirect_i = 1'b1;
        @(negedge clk);
        check("t5_flush", 32'(hz.flush_o), 1);
        check("t5_no_stall", 32'(hz.stall_o), 0);
        tick();
        nop();
        @(negedge clk);
        check("t5_slot_valid", 32'(hz.slot_valid_o), 32'b100);
        check("t5_flush_cnt", 32'(hz.flush_cnt_o), 1);
        tick();
        // Redirect coinciding with a load-use hazard: flush wins.
        set_in(1, 1, 1, 1, 1, 0, 0, 0); cyc();
        set_in(1, 1, 1, 1, 1, 2, 1, 1); cyc();
        set_in(1, 2, 1, 1, 1, 14, 1, 0);
        hz.redirect_i = 1'b1;
        @(negedge clk);
        check("t5b_flush", 32'(hz.flush_o), 1);
        check("t5b_no_bubble", 32'(hz.bubble_o), 0);
        tick();
        nop();
        @(negedge clk);
        check("t5b_flush_cnt", 32'(hz.flush_cnt_o), 2);
        check("t5b_stall_cnt", 32'(hz.stall_cnt_o), 1);
        tick();

        // Freeze over a pending load-use hazard holds everything.
        set_in(1, 1, 1, 1, 1, 5, 1, 1); cyc();
        set_in(1, 5, 1, 1, 1, 15, 1, 0);
        hz.freeze_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t6_frz_stall", 32'(hz.stall_o), 1);
            check("t6_frz_bubble", 32'(hz.bubble_o), 0);
            check("t6_frz_slots", 32'(hz.slot_valid_o), 32'b001);
            check("t6_frz_cnt", 32'(hz.stall_cnt_o), 1);
            tick();
        end
        hz.freeze_i = 1'b0;
        @(negedge clk); check("t6_bubble_after", 32'(hz.bubble_o), 1); tick();
        nop();
        @(negedge clk); check("t6_stall_cnt", 32'(hz.stall_cnt_o), 2); tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 1, 1, 1, 1, 5, 1, 1); cyc();
            set_in(1, 5, 1, 1, 1, 15, 1, 0); cyc();
            cyc();
        end
        nop();
        @(negedge clk);
        check("t6_stall_cnt_5", 32'(hz.stall_cnt_o), 5);
        check("t6_sat_stall_cnt", 32'(hz_sat.stall_cnt_o), 3);
        tick();

        // Asynchronous reset with a full scoreboard.
        set_in(1, 1, 1, 1, 1, 16, 1, 0); cyc();
        set_in(1, 1, 1, 1, 1, 17, 1, 0); cyc();
        set_in(1, 1, 1, 1, 1, 18, 1, 0); tick();
        @(negedge clk);
        check("t1_full", 32'(hz.slot_valid_o), 32'b111);
        #2 rst_n = 1'b0;
        #1;
        check("t1_slots", 32'(hz.slot_valid_o), 0);
        check("t1_stall_cnt", 32'(hz.stall_cnt_o), 0);
        check("t1_flush_cnt", 32'(hz.flush_cnt_o), 0);
        check("t1_sat_stall_cnt", 32'(hz_sat.stall_cnt_o), 0);
        tick();
        rst_n = 1'b1;

        // Randomized traffic; small register range to provoke dependencies.
        for (int c = 0; c < 3000; c++) begin
            set_in(int'($urandom_range(0, 3) != 0), $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
            hz.redirect_i = ($urandom_range(0, 7) == 0) && m_valid[RS];
            hz.freeze_i   = ($urandom_range(0, 9) == 0);
            tick();
        end
        nop();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
